i2c_slave_regfile: RTL



---
 rtl/i2c_slave_pkg.sv | 10 +
 rtl/i2c_bus_sync.sv | 37 +++
 rtl/i2c_slave_regfile.sv | 125 ++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared state type, byte width and pointer width helper for the I2C slave
package i2c_slave_pkg;
  localparam int I2C_BYTE_W = 8;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } slave_state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes scl/sda and detects SCL edges plus START/STOP conditions
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_s, scl_h, sda_h;
  // Resets to the idle-bus level so leaving reset never fakes an edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
      scl_h <= scl_s;
      sda_h <= sda_s;
    end
  end
  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave exposing a byte register file with an auto-incrementing pointer
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         DEPTH       = 16,
  parameter int         DATA_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = ptr_w(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  busy_o,
  output logic                  wr_stb_o,
  output logic [PTR_W-1:0]      wr_idx_o,
  output logic [DATA_WIDTH-1:0] wr_dat_o
);
  logic scl_rise, scl_fall, sda_s, start_det, stop_det;
  slave_state_t state;
  logic [2:0] bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg, rx_byte;
  logic [PTR_W-1:0] ptr;
  logic rw, ack_phase, byte_done;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign rx_byte   = {shreg[6:0], sda_s};
  assign byte_done = scl_rise && bit_cnt == 3'd7;

  // Protocol FSM: the shift register doubles as receive and transmit buffer; bit_cnt counts SCL rises
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_o     <= 1'b1;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_idx_o  <= '0;
      wr_dat_o  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_stb_o <= 1'b0;
      if (scl_rise) begin
        shreg   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        sda_o     <= 1'b1;
        busy_o    <= 1'b0;
        ack_phase <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_o     <= 1'b1;
        busy_o    <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          ADDR: if (byte_done) begin
            state  <= rx_byte[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
            busy_o <= rx_byte[7:1] == SLAVE_ADDR;
            rw     <= rx_byte[0];
          end
          PTR: if (byte_done) begin
            ptr   <= rx_byte[PTR_W-1:0];
            state <= PTR_ACK;
          end
          WDATA: if (byte_done) begin
            regs[ptr] <= rx_byte;
            wr_stb_o  <= 1'b1;
            wr_idx_o  <= ptr;
            wr_dat_o  <= rx_byte;
            ptr       <= ptr + 1'b1;
            state     <= WDATA_ACK;
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            ack_phase <= ~ack_phase;
            if (!ack_phase) sda_o <= 1'b0;
            else begin
              bit_cnt <= '0;
              shreg   <= regs[ptr];
              sda_o   <= state == ADDR_ACK && rw ? regs[ptr][7] : 1'b1;
              state   <= state != ADDR_ACK ? WDATA : rw ? RDATA : PTR;
            end
          end
          RDATA: if (scl_fall) begin
            sda_o <= bit_cnt == '0 ? 1'b1 : shreg[7];
            if (bit_cnt == '0) state <= RDATA_ACK;
          end
          RDATA_ACK: if (scl_rise) begin
            ptr <= ptr + 1'b1;
            if (sda_s) state <= IGNORE;
            else ack_phase <= 1'b1;
          end else if (scl_fall && ack_phase) begin
            ack_phase <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= regs[ptr];
            sda_o     <= regs[ptr][7];
            state     <= RDATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
